// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//   Owns the fetch PC and applies control-flow redirects coming from the ID
//   stage (JAL/JALR resolved, conditional branches predicted taken). Each
//   predicted-taken branch is tracked until EX resolves it; a not-taken
//   resolution restores the fall-through PC. Redirects that arrive while fetch
//   is stalled are parked in a one-entry pending register and applied on the
//   first unstalled cycle.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   stall_i              fetch hold; PC does not advance, nothing is applied
//   id_redirect_i        ID-stage redirect request
//   id_target_i          redirect target from ID
//   id_is_cond_i         redirect is a conditional branch (predicted taken)
//   id_pc_i              PC of the instruction in ID
//   ex_valid_i           a tracked branch resolves in EX this cycle
//   ex_taken_i           resolved branch condition
//   pc_o                 current fetch PC
//   flush_if_o           kill IF/ID (any applied redirect)
//   flush_id_o           kill ID/EX (applied EX correction only)
//   pending_o            a redirect is parked behind a stall
//   misalign_o           applied target had bit1 set
//   redirect_cnt_o       applied ID redirects (wraps)
//   mispredict_cnt_o     applied EX corrections (wraps)
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             id_redirect_i,
  input  logic [31:0]      id_target_i,
  input  logic             id_is_cond_i,
  input  logic [31:0]      id_pc_i,
  input  logic             ex_valid_i,
  input  logic             ex_taken_i,
  output logic [31:0]      pc_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             pending_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

  // One redirect: raw target plus its origin (EX correction vs ID redirect).
  typedef struct packed {
    logic [31:0] tgt;
    logic        is_ex;
  } redir_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  redir_t           pend_q, pend_d;
  logic             trk_vld_q, trk_vld_d;
  logic [31:0]      trk_ft_q, trk_ft_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             ex_corr;
  logic             apply;
  redir_t           app;
  redir_t           corr_req;
  redir_t           id_req;

  // A not-taken resolution of the tracked branch: fetch went down the wrong
  // path, go back to the fall-through address.
  assign ex_corr  = ex_valid_i & trk_vld_q & ~ex_taken_i;
  assign corr_req = '{tgt: trk_ft_q,    is_ex: 1'b1};
  assign id_req   = '{tgt: id_target_i, is_ex: 1'b0};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    trk_vld_d = trk_vld_q;
    trk_ft_d  = trk_ft_q;
    rcnt_d    = rcnt_q;
    mcnt_d    = mcnt_q;
    apply     = 1'b0;
    app       = corr_req;

    // Any resolution of the tracked branch retires it, taken or not.
    if (ex_valid_i && trk_vld_q) trk_vld_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ex_corr) begin
          // A simultaneous ID request is wrong-path and is dropped.
          app = corr_req;
        end else if (id_redirect_i) begin
          app = id_req;
          // Tracked as soon as accepted, whether applied now or parked.
          if (id_is_cond_i) begin
            trk_vld_d = 1'b1;
            trk_ft_d  = id_pc_i + 32'd4;
          end
        end

        if (ex_corr || id_redirect_i) begin
          if (stall_i) begin
            pend_d  = app;
            state_d = PEND;
          end else begin
            apply = 1'b1;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end

      PEND: begin
        // The parked ID instruction is still sitting in ID, so live ID
        // requests are repeats and are ignored here.
        if (stall_i) begin
          if (ex_corr) pend_d = corr_req;
        end else begin
          apply   = 1'b1;
          app     = ex_corr ? corr_req : pend_q;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    if (apply) begin
      pc_d = {app.tgt[31:1], 1'b0};
      if (app.is_ex) mcnt_d = mcnt_q + CNT_W'(1);
      else           rcnt_d = rcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      trk_vld_q <= 1'b0;
      trk_ft_q  <= '0;
      rcnt_q    <= '0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      trk_vld_q <= trk_vld_d;
      trk_ft_q  <= trk_ft_d;
      rcnt_q    <= rcnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  // Pulses live only in the apply cycle, which never happens under stall.
  assign flush_if_o       = apply;
  assign flush_id_o       = apply & app.is_ex;
  assign misalign_o       = apply & app.tgt[1];
  assign pc_o             = pc_q;
  assign pending_o        = (state_q == PEND);
  assign redirect_cnt_o   = rcnt_q;
  assign mispredict_cnt_o = mcnt_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-side consumer of the ID-stage branch/jump target logic. Owns the program counter and applies ID redirects: branches are predicted taken and JAL/JALR are resolved in ID. Tracks each predicted-taken conditional branch until the EX stage resolves its condition, and restores the fall-through PC on a mispredict. Also generates the IF/ID and ID/EX flush strobes, buffers redirects that arrive during a fetch stall, and keeps redirect and mispredict counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the redirect and mispredict counters.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
stall_i  input  1  fetch hold from the hazard unit; PC must not advance.
id_redirect_i  input  1  ID-stage redirect request (branch, JAL or JALR opcode).
id_target_i  input  32  redirect target computed in ID.
id_is_cond_i  input  1  the ID redirect is a conditional branch (predicted taken).
id_pc_i  input  32  PC of the instruction in ID.
ex_valid_i  input  1  a conditional branch's condition is resolved in EX this cycle.
ex_taken_i  input  1  resolved condition; valid only with ex_valid_i.
pc_o  output  32  current fetch PC.
flush_if_o  output  1  kill IF/ID register contents.
flush_id_o  output  1  kill ID/EX register contents.
pending_o  output  1  a redirect is buffered behind a stall.
misalign_o  output  1  applied target had bit1 set (one-cycle pulse).
redirect_cnt_o  output  CNT_W  count of applied ID redirects, wraps.
mispredict_cnt_o  output  CNT_W  count of applied EX corrections, wraps.

Behaviour:
- Reset (async, rst_ni=0) values:
  - pc_o=RESET_PC; all flags 0; counters 0.
  - State RUN; tracker cleared (trk_vld=0, trk_ft=0).
  - Reset mid-operation discards any pending or tracked redirect.
- Target sanitising: the applied target is target with bit0 forced to 0. If bit1=1 the target is still loaded and misalign_o pulses high in the apply cycle.
- Request sources, evaluated each cycle, in priority order:
  1. EX correction: ex_valid_i & trk_vld & !ex_taken_i. Target = trk_ft.
  2. ID redirect: id_redirect_i, target = id_target_i.
  3. Sequential fetch: pc_o + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
- When both EX correction and ID redirect are present, the ID request is wrong-path: it is dropped and does not load the tracker.
- ex_valid_i with trk_vld=0 is ignored. ex_valid_i & ex_taken_i clears trk_vld with no redirect.
- Tracker: when an ID redirect with id_is_cond_i is applied or buffered, trk_vld<=1 and trk_ft<=id_pc_i+4. An EX correction clears trk_vld.
- State machine with two states, RUN and PEND:
  - RUN, stall_i=0, request present: PC <= target next edge (1-cycle latency). Counters update.
    - ID redirect: flush_if_o=1 that cycle.
    - EX correction: flush_if_o=1 and flush_id_o=1 that cycle.
  - RUN, stall_i=0, no request: PC <= PC+4.
  - RUN, stall_i=1, no request: PC holds.
  - RUN, stall_i=1, request present: capture target and kind into the pending register -> PEND. PC holds, no flush, pending_o=1 from next cycle.
  - PEND, stall_i=1: PC holds.
    - A new EX correction overwrites the pending entry.
    - A repeated or new ID redirect is ignored (same instruction held in ID).
  - PEND, stall_i=0: apply the pending entry exactly as in RUN (PC load, flushes per kind, counter increment) -> RUN.
    - An EX correction arriving in this same cycle overrides the pending entry.
    - Live ID requests are ignored this cycle.
- Flushes and misalign_o are combinational pulses in the apply cycle only. They are never asserted while stall_i=1.
- Counters increment by 1 per applied redirect and wrap at 2^CNT_W.

Test Plan:
- Reset with RESET_PC=32'h100, no stimulus for 3 clocks -> pc_o = 0x100, 0x104, 0x108, 0x10C; all flags 0.
- JAL in ID at id_pc_i=0x20, id_target_i=0x80, id_is_cond_i=0 -> flush_if_o=1 for one cycle; next pc_o=0x80; redirect_cnt_o=1; trk_vld stays 0.
- Branch at 0x40 predicted to 0x200, then ex_valid_i=1 with ex_taken_i=0 one cycle later -> pc_o=0x200, then flush_if_o=1 and flush_id_o=1 together, next pc_o=0x44; mispredict_cnt_o=1. Same sequence with ex_taken_i=1 -> no flush, pc_o continues to 0x204.
- stall_i=1 for 3 cycles with id_redirect_i=1 to 0x300 held throughout -> pc_o frozen, pending_o=1, no flushes. On the first cycle with stall_i=0: flush_if_o=1, next pc_o=0x300, redirect_cnt_o increments by exactly 1.
- Same cycle: EX correction (trk_ft=0x48) and ID redirect to 0x500 -> pc_o=0x48, both flushes high, redirect_cnt_o unchanged, trk_vld=0.
- JALR target 0x403 -> pc_o=0x402 and misalign_o pulses. Separately, assert rst_ni=0 mid-PEND -> pc_o=RESET_PC immediately and pending_o=0.
